alarm_clock_core: RTL and testbench
===================================

ALARM_CLOCK_CORE -- requirements
Module: alarm_clock_core

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameters SHALL be, one per line:
- CLK_DIV, 100000000, clk cycles per one-second tick (>=2)
- FMT_12H, 0, 1 = 12-hour display with pm flag, 0 = 24-hour display
- ALARM_LEN, 60, seconds ringing lasts unless stopped
REQ-003 Ports SHALL be, one per line:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enb  in  1  timekeeping enable
- set_mode  in  1  1 = setting mode; timekeeping frozen
- btn  in  4  synchronised button levels; [0] min+1, [1] hour+1, [2] min-1, [3] toggle set target (time/alarm)
- alarm_en  in  1  alarm armed
- hour  out  6  displayed hour (0-23, or 1-12 when FMT_12H)
- min  out  6  minutes 0-59
- sec  out  6  seconds 0-59
- pm  out  1  hour>=12 (0 when FMT_12H=0)
- alarm_hour  out  6  alarm hour, 0-23 always
- alarm_min  out  6  alarm minute 0-59
- target_alarm  out  1  set target: 0 time, 1 alarm
- ringing  out  1  alarm active
- tick  out  1  one-cycle pulse per second tick

Function
REQ-004 Each btn bit SHALL produce a one-cycle press pulse on its registered 0->1 transition; one cycle latency from btn to pulse.
REQ-005 Prescaler SHALL count 0..CLK_DIV-1 while enb=1 and set_mode=0, pulse tick on the cycle count equals CLK_DIV-1, then wrap to 0; it SHALL hold its value otherwise.
REQ-006 On tick, sec SHALL increment; 59->0 carries to min; min 59->0 carries to internal hour; hour 23->0; all updates on the same edge.
REQ-007 Press pulses SHALL act only when set_mode=1; when set_mode=0 they only stop ringing (REQ-012).
REQ-008 In set_mode, btn[0]/btn[2] SHALL increment/decrement the target minute modulo 60 with no carry to hour; btn[1] SHALL increment target hour modulo 24; adjusting time minutes SHALL clear sec to 0.
REQ-009 btn[3] press in set_mode SHALL toggle target_alarm; leaving set_mode SHALL not change target_alarm.
REQ-010 Simultaneous pulses in one cycle SHALL resolve by priority btn[3] > btn[0] > btn[2] > btn[1]; lower ones are dropped.
REQ-011 Display: FMT_12H=1 maps internal 0->12, 1-12->same, 13-23->minus 12, pm=internal>=12; FMT_12H=0 passes hour through, pm=0.
REQ-012 ringing SHALL assert on the cycle after a tick that makes sec=0 with internal hour:min equal alarm_hour:alarm_min and alarm_en=1; it SHALL clear after ALARM_LEN ticks, on any press pulse, on alarm_en=0, or on entering set_mode, whichever first.
REQ-013 A press pulse and an alarm-match tick in the same cycle SHALL leave ringing=0.
REQ-014 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-015 rst SHALL have priority over all other inputs and, on the next clk edge, set: sec=min=0, internal hour=0 (displayed 12 with pm=0 when FMT_12H=1, else 0), alarm_hour=6, alarm_min=0, target_alarm=0, ringing=0, tick=0, prescaler=0, edge-detect history=0.
REQ-016 rst asserted mid-ring or mid-setting SHALL abort the operation with no residual pulse after release.

Structure
REQ-017 A shared package SHALL hold limit constants (SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23), alarm reset defaults, and the button index constants.
REQ-018 The prescaler SHALL be a separate sub-module tick_prescaler (parameter CLK_DIV; ports clk, rst, run, tick).

Verification (CLK_DIV=4, ALARM_LEN=3)
REQ-019 Reset then enb=1 for 240 clk -> tick every 4th cycle, sec 0..59 then min=1, sec=0.
REQ-020 Preload 23:59:58 via set_mode then 2 ticks -> hour=0, min=0, sec=0; FMT_12H=1 shows hour=12, pm=0.
REQ-021 set_mode=1, btn[2] press at min=0 -> min=59, hour unchanged, sec=0; btn[0] and btn[1] same cycle -> only min+1.
REQ-022 Alarm at 06:01, time 06:00:59, alarm_en=1 -> ringing=1 after next tick, clears after 3 further ticks; repeat with btn[0] press -> ringing clears next cycle.
REQ-023 rst asserted while ringing=1 and target_alarm=1 -> all outputs at REQ-015 values on next edge, tick=0.

Source files
------------

// File: rtl/alarm_clock_core_pkg.sv
// Shared constants and helpers for the alarm clock core.
//   - Time-field limits (seconds, minutes, hours of the internal 24-hour count)
//   - Alarm reset defaults
//   - Button bit positions within the btn bus
//   - Set-mode adjustment kinds and wrap/format helpers
package alarm_clock_core_pkg;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] HOUR_MAX = 6'd23;

  localparam logic [5:0] ALARM_HOUR_RST = 6'd6;
  localparam logic [5:0] ALARM_MIN_RST  = 6'd0;

  localparam int unsigned BTN_MIN_INC  = 0;
  localparam int unsigned BTN_HOUR_INC = 1;
  localparam int unsigned BTN_MIN_DEC  = 2;
  localparam int unsigned BTN_TARGET   = 3;

  typedef enum logic [2:0] {
    ADJ_NONE,
    ADJ_TOGGLE,
    ADJ_MIN_INC,
    ADJ_MIN_DEC,
    ADJ_HOUR_INC
  } adj_e;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? '0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
    return (v == '0) ? max : v - 6'd1;
  endfunction

  // Internal 0..23 hour to 12-hour display value 1..12.
  function automatic logic [5:0] hour_to_12h(input logic [5:0] h);
    if (h == '0)
      return 6'd12;
    else if (h > 6'd12)
      return h - 6'd12;
    else
      return h;
  endfunction

endpackage

// File: rtl/alarm_clock_core_prescaler.sv
// tick_prescaler: divides clk down to a one-second tick.
//   clk  - system clock
//   rst  - synchronous active-high reset, clears the count
//   run  - count advances only while high, otherwise it holds
//   tick - high during the cycle in which the count sits at CLK_DIV-1
//          while running; the count wraps to 0 on that edge
module tick_prescaler #(
  parameter int unsigned CLK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (run)
      cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alarm_clock_core.sv
// alarm_clock_core: timekeeping, set-mode adjustment and alarm ringing.
//   clk, rst      - clock and synchronous active-high reset
//   enb           - timekeeping enable
//   set_mode      - 1 = setting mode, timekeeping frozen
//   btn[3:0]      - button levels: [0] min+1, [1] hour+1, [2] min-1, [3] toggle target
//   alarm_en      - alarm armed
//   hour/min/sec  - displayed time (hour 1..12 with pm when FMT_12H, else 0..23)
//   pm            - afternoon flag in 12-hour mode, 0 otherwise
//   alarm_hour/alarm_min - alarm setting, 24-hour
//   target_alarm  - set-mode target: 0 time, 1 alarm
//   ringing       - alarm active
//   tick          - one-cycle pulse per second tick
// All outputs come straight from registers.
module alarm_clock_core
  import alarm_clock_core_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 100000000,
  parameter bit          FMT_12H   = 1'b0,
  parameter int unsigned ALARM_LEN = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       set_mode,
  input  logic [3:0] btn,
  input  logic       alarm_en,
  output logic [5:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       pm,
  output logic [5:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       target_alarm,
  output logic       ringing,
  output logic       tick
);

  localparam int unsigned RW = $clog2(ALARM_LEN + 1);
  localparam logic [5:0] HOUR_DISP_RST = FMT_12H ? 6'd12 : 6'd0;

  logic [3:0]    btn_q, press_q;
  logic [5:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [5:0]    alarm_hour_q, alarm_hour_d, alarm_min_q, alarm_min_d;
  logic [5:0]    disp_hour_q, disp_hour_d;
  logic          pm_q, pm_d;
  logic          target_q, target_d;
  logic          ring_q, ring_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic          tick_q;
  logic          sec_tick;
  logic          match;
  adj_e          adj;

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (enb && !set_mode),
    .tick (sec_tick)
  );

  always_comb begin
    adj = ADJ_NONE;
    if (set_mode) begin
      if (press_q[BTN_TARGET])
        adj = ADJ_TOGGLE;
      else if (press_q[BTN_MIN_INC])
        adj = ADJ_MIN_INC;
      else if (press_q[BTN_MIN_DEC])
        adj = ADJ_MIN_DEC;
      else if (press_q[BTN_HOUR_INC])
        adj = ADJ_HOUR_INC;
    end
  end

  always_comb begin
    sec_d        = sec_q;
    min_d        = min_q;
    hour_d       = hour_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    target_d     = target_q;
    ring_d       = ring_q;
    ring_cnt_d   = ring_cnt_q;

    // Ticks only happen outside set_mode, so they never collide with adjustments.
    if (sec_tick) begin
      sec_d = wrap_inc(sec_q, SEC_MAX);
      if (sec_q == SEC_MAX) begin
        min_d = wrap_inc(min_q, MIN_MAX);
        if (min_q == MIN_MAX)
          hour_d = wrap_inc(hour_q, HOUR_MAX);
      end
    end

    unique case (adj)
      ADJ_TOGGLE:  target_d = !target_q;
      ADJ_MIN_INC: begin
        if (target_q)
          alarm_min_d = wrap_inc(alarm_min_q, MIN_MAX);
        else begin
          min_d = wrap_inc(min_q, MIN_MAX);
          sec_d = '0;
        end
      end
      ADJ_MIN_DEC: begin
        if (target_q)
          alarm_min_d = wrap_dec(alarm_min_q, MIN_MAX);
        else begin
          min_d = wrap_dec(min_q, MIN_MAX);
          sec_d = '0;
        end
      end
      ADJ_HOUR_INC: begin
        if (target_q)
          alarm_hour_d = wrap_inc(alarm_hour_q, HOUR_MAX);
        else
          hour_d = wrap_inc(hour_q, HOUR_MAX);
      end
      default: ;
    endcase

    // A match is the tick that rolls seconds to 0 onto the alarm minute.
    match = sec_tick && alarm_en && (sec_q == SEC_MAX) &&
            (hour_d == alarm_hour_q) && (min_d == alarm_min_q);

    // Stop conditions outrank a fresh match, so a press on the match tick wins.
    if ((|press_q) || !alarm_en || set_mode) begin
      ring_d     = 1'b0;
      ring_cnt_d = '0;
    end else if (match) begin
      ring_d     = 1'b1;
      ring_cnt_d = '0;
    end else if (ring_q && sec_tick) begin
      if (ring_cnt_q == RW'(ALARM_LEN - 1)) begin
        ring_d     = 1'b0;
        ring_cnt_d = '0;
      end else begin
        ring_cnt_d = ring_cnt_q + RW'(1);
      end
    end

    disp_hour_d = FMT_12H ? hour_to_12h(hour_d) : hour_d;
    pm_d        = FMT_12H && (hour_d >= 6'd12);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q        <= '0;
      press_q      <= '0;
      sec_q        <= '0;
      min_q        <= '0;
      hour_q       <= '0;
      alarm_hour_q <= ALARM_HOUR_RST;
      alarm_min_q  <= ALARM_MIN_RST;
      target_q     <= 1'b0;
      ring_q       <= 1'b0;
      ring_cnt_q   <= '0;
      tick_q       <= 1'b0;
      disp_hour_q  <= HOUR_DISP_RST;
      pm_q         <= 1'b0;
    end else begin
      btn_q        <= btn;
      press_q      <= btn & ~btn_q;
      sec_q        <= sec_d;
      min_q        <= min_d;
      hour_q       <= hour_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      target_q     <= target_d;
      ring_q       <= ring_d;
      ring_cnt_q   <= ring_cnt_d;
      tick_q       <= sec_tick;
      disp_hour_q  <= disp_hour_d;
      pm_q         <= pm_d;
    end
  end

  assign hour         = disp_hour_q;
  assign min          = min_q;
  assign sec          = sec_q;
  assign pm           = pm_q;
  assign alarm_hour   = alarm_hour_q;
  assign alarm_min    = alarm_min_q;
  assign target_alarm = target_q;
  assign ringing      = ring_q;
  assign tick         = tick_q;

endmodule

// File: tb/tb_alarm_clock_core.sv
// Self-checking bench for alarm_clock_core with CLK_DIV=4, ALARM_LEN=3.
// Two instances share stimulus: a 24-hour one and a 12-hour one.
// The reference model keeps time as seconds-of-day and the alarm as
// minutes-of-day and is advanced once per clock edge.
module tb_alarm_clock_core;

  localparam int unsigned DIV  = 4;
  localparam int unsigned ALEN = 3;

  logic       clk = 1'b0;
  logic       rst, enb, set_mode, alarm_en;
  logic [3:0] btn;

  logic [5:0] hour, min, sec, ahour, amin;
  logic       pm, tgt, ring, tick;
  logic [5:0] hour12, min12, sec12, ahour12, amin12;
  logic       pm12, tgt12, ring12, tick12;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state
  int   m_pre, m_tod, m_alarm, m_cnt;
  bit   m_tgt, m_ring, m_tick;
  logic [3:0] m_prev, m_press;

  always #5 clk = ~clk;

  alarm_clock_core #(.CLK_DIV(DIV), .FMT_12H(1'b0), .ALARM_LEN(ALEN)) u24 (
    .clk(clk), .rst(rst), .enb(enb), .set_mode(set_mode), .btn(btn), .alarm_en(alarm_en),
    .hour(hour), .min(min), .sec(sec), .pm(pm), .alarm_hour(ahour), .alarm_min(amin),
    .target_alarm(tgt), .ringing(ring), .tick(tick));

  alarm_clock_core #(.CLK_DIV(DIV), .FMT_12H(1'b1), .ALARM_LEN(ALEN)) u12 (
    .clk(clk), .rst(rst), .enb(enb), .set_mode(set_mode), .btn(btn), .alarm_en(alarm_en),
    .hour(hour12), .min(min12), .sec(sec12), .pm(pm12), .alarm_hour(ahour12), .alarm_min(amin12),
    .target_alarm(tgt12), .ringing(ring12), .tick(tick12));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_update();
    int h, mi, s;
    bit run, tk, match;
    if (rst) begin
      m_pre = 0; m_tod = 0; m_alarm = 6 * 60; m_cnt = 0;
      m_tgt = 0; m_ring = 0; m_tick = 0; m_prev = '0; m_press = '0;
    end else begin
      run = enb && !set_mode;
      tk  = run && (m_pre == int'(DIV) - 1);
      if (run) m_pre = (m_pre + 1) % int'(DIV);
      h  = m_tod / 3600;
      mi = (m_tod / 60) % 60;
      s  = m_tod % 60;
      if (set_mode && m_press != 0) begin
        if (m_press[3])
          m_tgt = !m_tgt;
        else if (m_press[0] || m_press[2]) begin
          if (m_tgt)
            m_alarm = (m_alarm / 60) * 60 + ((m_alarm % 60) + (m_press[0] ? 1 : 59)) % 60;
          else
            m_tod = h * 3600 + ((mi + (m_press[0] ? 1 : 59)) % 60) * 60;
        end else begin
          if (m_tgt)
            m_alarm = (((m_alarm / 60) + 1) % 24) * 60 + m_alarm % 60;
          else
            m_tod = ((h + 1) % 24) * 3600 + mi * 60 + s;
        end
      end
      match = 0;
      if (tk) begin
        m_tod = (m_tod + 1) % 86400;
        match = alarm_en && (m_tod % 60 == 0) && (m_tod / 60 == m_alarm);
      end
      if (m_press != 0 || !alarm_en || set_mode)
        m_ring = 0;
      else if (match) begin
        m_ring = 1; m_cnt = 0;
      end else if (m_ring && tk) begin
        m_cnt++;
        if (m_cnt == int'(ALEN)) m_ring = 0;
      end
      m_tick  = tk;
      m_press = btn & ~m_prev;
      m_prev  = btn;
    end
  endtask

  task automatic check_all();
    int h, h12;
    h   = m_tod / 3600;
    h12 = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    chk("hour",     {2'b0, hour},    8'(h));
    chk("min",      {2'b0, min},     8'((m_tod / 60) % 60));
    chk("sec",      {2'b0, sec},     8'(m_tod % 60));
    chk("pm",       {7'b0, pm},      8'd0);
    chk("ahour",    {2'b0, ahour},   8'(m_alarm / 60));
    chk("amin",     {2'b0, amin},    8'(m_alarm % 60));
    chk("target",   {7'b0, tgt},     8'(m_tgt));
    chk("ringing",  {7'b0, ring},    8'(m_ring));
    chk("tick",     {7'b0, tick},    8'(m_tick));
    chk("hour12",   {2'b0, hour12},  8'(h12));
    chk("pm12",     {7'b0, pm12},    8'(h >= 12));
    chk("min12",    {2'b0, min12},   8'((m_tod / 60) % 60));
    chk("sec12",    {2'b0, sec12},   8'(m_tod % 60));
    chk("ring12",   {7'b0, ring12},  8'(m_ring));
    chk("tgt12",    {7'b0, tgt12},   8'(m_tgt));
    chk("tick12",   {7'b0, tick12},  8'(m_tick));
    chk("ahour12",  {2'b0, ahour12}, 8'(m_alarm / 60));
    chk("amin12",   {2'b0, amin12},  8'(m_alarm % 60));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_update();
      #1;
      check_all();
    end
  endtask

  task automatic press(input int idx);
    btn = '0;
    btn[idx] = 1'b1;
    run(1);
    btn = '0;
    run(2);
  endtask

  // Bring time from hh:01:xx back to hh:00:00, then run to hh:00:59.
  task automatic back_to_59();
    set_mode = 1'b1;
    press(2);
    set_mode = 1'b0;
    run(59 * DIV);
  endtask

  initial begin
    rst = 1'b1; enb = 1'b0; set_mode = 1'b0; alarm_en = 1'b0; btn = '0;
    run(2);
    chk("rst_hour12", {2'b0, hour12}, 8'd12);
    chk("rst_ahour",  {2'b0, ahour},  8'd6);

    // one minute of free-running time
    rst = 1'b0; enb = 1'b1;
    run(240);
    chk("run_min", {2'b0, min}, 8'd1);
    chk("run_sec", {2'b0, sec}, 8'd0);

    // preload 23:59:58 and roll over midnight
    set_mode = 1'b1;
    repeat (23) press(1);
    press(2); press(2);
    set_mode = 1'b0;
    run(58 * DIV);
    chk("pre_hour",   {2'b0, hour},   8'd23);
    chk("pre_sec",    {2'b0, sec},    8'd58);
    chk("pre_hour12", {2'b0, hour12}, 8'd11);
    chk("pre_pm12",   {7'b0, pm12},   8'd1);
    run(2 * DIV);
    chk("mid_hour",   {2'b0, hour},   8'd0);
    chk("mid_min",    {2'b0, min},    8'd0);
    chk("mid_hour12", {2'b0, hour12}, 8'd12);
    chk("mid_pm12",   {7'b0, pm12},   8'd0);

    // minute decrement wrap and simultaneous-press priority
    set_mode = 1'b1;
    press(2);
    chk("dec_min",  {2'b0, min},  8'd59);
    chk("dec_hour", {2'b0, hour}, 8'd0);
    btn = 4'b0011; run(1); btn = '0; run(2);
    chk("prio_min",  {2'b0, min},  8'd0);
    chk("prio_hour", {2'b0, hour}, 8'd0);

    // alarm at 06:01, time 06:00:00
    press(3);
    chk("tgt_on", {7'b0, tgt}, 8'd1);
    press(0);
    chk("alarm_min", {2'b0, amin}, 8'd1);
    press(3);
    repeat (6) press(1);
    set_mode = 1'b0; alarm_en = 1'b1;
    run(59 * DIV);
    chk("pre_ring", {7'b0, ring}, 8'd0);
    run(DIV);
    chk("ring_on", {7'b0, ring}, 8'd1);
    run(3 * DIV - 1);
    chk("ring_hold", {7'b0, ring}, 8'd1);
    run(1);
    chk("ring_len", {7'b0, ring}, 8'd0);

    // press stops the ring
    back_to_59();
    run(DIV);
    chk("ring2_on", {7'b0, ring}, 8'd1);
    btn = 4'b0001; run(1);
    chk("ring2_pend", {7'b0, ring}, 8'd1);
    btn = '0; run(1);
    chk("ring2_stop", {7'b0, ring}, 8'd0);
    run(2);

    // press pulse on the matching tick suppresses the ring
    back_to_59();
    run(2);
    btn = 4'b0001; run(1);
    btn = '0; run(1);
    chk("coinc_ring", {7'b0, ring}, 8'd0);
    chk("coinc_min",  {2'b0, min},  8'd1);

    // reset while ringing with alarm target selected
    set_mode = 1'b1;
    press(2);
    press(3);
    set_mode = 1'b0;
    run(60 * DIV);
    chk("pre_rst_ring", {7'b0, ring}, 8'd1);
    chk("pre_rst_tgt",  {7'b0, tgt},  8'd1);
    rst = 1'b1;
    run(1);
    chk("rst_ring", {7'b0, ring}, 8'd0);
    chk("rst_tgt",  {7'b0, tgt},  8'd0);
    chk("rst_tick", {7'b0, tick}, 8'd0);
    chk("rst_amin", {2'b0, amin}, 8'd0);
    rst = 1'b0;
    run(8);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      enb = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) set_mode = !set_mode;
      if ($urandom_range(0, 199) == 0) alarm_en = !alarm_en;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) btn[b] = !btn[b];
      run(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
